// File: rtl/i2s_clk_gen.sv
// Master-mode I2S/TDM clock and frame sequencer: divides mclk to bclk, frames lrck, starts/stops on frame boundaries.
// Optional macro I2S_CLK_GEN_FREE_BCLK_EN: bclk free-runs from the live divider while idle.

module i2s_clk_gen #(
  parameter int DIV_W       = 8,
  parameter int FRAME_CNT_W = 32
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [DIV_W-1:0]       i_bclk_div,
  input  logic [4:0]             i_tdm_num,
  input  logic                   i_lrck_polarity,
  output logic                   o_bclk,
  output logic                   o_lrck,
  output logic                   o_bclk_rise,
  output logic                   o_bclk_fall,
  output logic                   o_frame_start,
  output logic                   o_busy,
  output logic [FRAME_CNT_W-1:0] o_frame_num,
  output logic                   o_cfg_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic [DIV_W-1:0]       half_cnt_q;
  logic [DIV_W-1:0]       div_q;
  logic [8:0]             bit_idx_q;
  logic [4:0]             tdm_q;
  logic                   pol_q;
  logic                   bclk_q;
  logic                   lrck_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   frame_start_q;
  logic                   cfg_error_q;
  logic [FRAME_CNT_W-1:0] frame_num_q;

  logic                   cfg_valid;
  logic                   half_wrap;
  logic                   frame_last;
  logic                   lrck_active_d;
  logic [8:0]             bit_idx_d;
  logic [9:0]             frame_last_idx;
  logic [9:0]             active_limit;

  assign cfg_valid      = (i_bclk_div != '0) && (i_tdm_num != 5'd0) && (i_tdm_num <= 5'd16);
  assign half_wrap      = (half_cnt_q == div_q - DIV_W'(1));
  assign frame_last_idx = {tdm_q, 5'd0} - 10'd1;
  assign frame_last     = ({1'b0, bit_idx_q} == frame_last_idx);
  assign bit_idx_d      = bit_idx_q + 9'd1;
  // Stereo modes get a 50% lrck; wider TDM frames get a one-slot sync pulse.
  assign active_limit   = (tdm_q <= 5'd2) ? {1'b0, tdm_q, 4'd0} : 10'd32;
  assign lrck_active_d  = ({1'b0, bit_idx_d} < active_limit);

`ifdef I2S_CLK_GEN_FREE_BCLK_EN
  logic idle_wrap;
  assign idle_wrap = (half_cnt_q >= i_bclk_div - DIV_W'(1));
`endif

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      half_cnt_q    <= '0;
      div_q         <= '0;
      bit_idx_q     <= '0;
      tdm_q         <= '0;
      pol_q         <= 1'b0;
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      frame_start_q <= 1'b0;
      cfg_error_q   <= 1'b0;
      frame_num_q   <= '0;
    end else begin
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_enable && cfg_valid) begin
            state_q       <= RUN;
            div_q         <= i_bclk_div;
            tdm_q         <= i_tdm_num;
            pol_q         <= i_lrck_polarity;
            half_cnt_q    <= '0;
            bit_idx_q     <= '0;
            bclk_q        <= 1'b0;
            lrck_q        <= ~i_lrck_polarity;
            frame_start_q <= 1'b1;
            frame_num_q   <= frame_num_q + FRAME_CNT_W'(1);
`ifdef I2S_CLK_GEN_FREE_BCLK_EN
            fall_q        <= bclk_q;
`endif
          end else begin
            if (i_enable) begin
              cfg_error_q <= 1'b1;
            end
`ifdef I2S_CLK_GEN_FREE_BCLK_EN
            if (i_bclk_div == '0) begin
              half_cnt_q <= '0;
              bclk_q     <= 1'b0;
              fall_q     <= bclk_q;
            end else if (idle_wrap) begin
              half_cnt_q <= '0;
              bclk_q     <= ~bclk_q;
              rise_q     <= ~bclk_q;
              fall_q     <= bclk_q;
            end else begin
              half_cnt_q <= half_cnt_q + DIV_W'(1);
            end
`else
            half_cnt_q <= '0;
            bclk_q     <= 1'b0;
`endif
          end
        end

        RUN, DRAIN: begin
          if (state_q == RUN && !i_enable) begin
            state_q <= DRAIN;
          end else if (state_q == DRAIN && i_enable) begin
            state_q <= RUN;
          end
          if (half_wrap) begin
            half_cnt_q <= '0;
            if (!bclk_q) begin
              bclk_q <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              bclk_q <= 1'b0;
              fall_q <= 1'b1;
              if (!frame_last) begin
                bit_idx_q <= bit_idx_d;
                lrck_q    <= lrck_active_d ^ pol_q;
              end else if (state_q == RUN || i_enable) begin
                // Frame boundary: the only place a new config takes effect.
                bit_idx_q     <= '0;
                frame_start_q <= 1'b1;
                frame_num_q   <= frame_num_q + FRAME_CNT_W'(1);
                state_q       <= i_enable ? RUN : DRAIN;
                if (cfg_valid) begin
                  div_q  <= i_bclk_div;
                  tdm_q  <= i_tdm_num;
                  pol_q  <= i_lrck_polarity;
                  lrck_q <= ~i_lrck_polarity;
                end else begin
                  lrck_q <= ~pol_q;
                end
              end else begin
                state_q   <= IDLE;
                bit_idx_q <= '0;
              end
            end
          end else begin
            half_cnt_q <= half_cnt_q + DIV_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_bclk        = bclk_q;
  assign o_lrck        = (state_q == IDLE) ? i_lrck_polarity : lrck_q;
  assign o_bclk_rise   = rise_q;
  assign o_bclk_fall   = fall_q;
  assign o_frame_start = frame_start_q;
  assign o_busy        = (state_q != IDLE);
  assign o_frame_num   = frame_num_q;
  assign o_cfg_error   = cfg_error_q;

endmodule
